// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: control codes used by the ALU control decoder and the
// execution unit, execution-unit state encoding, and the registered flag bundle.
package alu_defs_pkg;

    localparam int unsigned ALU_CTRL_W = 3;

    typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD = 3'b000;
    localparam alu_ctrl_t ALU_SUB = 3'b001;
    localparam alu_ctrl_t ALU_AND = 3'b010;
    localparam alu_ctrl_t ALU_OR  = 3'b011;
    localparam alu_ctrl_t ALU_SLL = 3'b100;
    localparam alu_ctrl_t ALU_SRL = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic illegal;
    } alu_flags_t;

    function automatic logic alu_is_shift(input alu_ctrl_t op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_shift_serial.sv
// Serial shifter: one bit per enabled cycle with zero fill, counting down the
// shift amount; last_c flags that the register holds the final value.
module alu_shift_serial #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift_en,
    input  logic               dir_right,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] amt,
    output logic [WIDTH-1:0]   dout,
    output logic               last_c
);

    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = din;
            cnt_d   = amt;
        end else if (shift_en && (cnt_q != '0)) begin
            shreg_d = dir_right ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout   = shreg_q;
    assign last_c = (cnt_q == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit with start/ready/done handshake.
// Define ALU_FAST_SHIFT_EN to replace the serial shifter with a one-cycle barrel shift.
module alu_exec_unit
    import alu_defs_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         ALU_control,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               illegal
);

    alu_state_e       state_q, state_d;
    alu_ctrl_t        op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] shift_value_c;
    logic             calc_last_c;
    logic [WIDTH-1:0] calc_result_c;
    alu_flags_t       calc_flags_c;
    logic [WIDTH-1:0] sum_c, diff_c;

`ifdef ALU_FAST_SHIFT_EN
    logic [SHAMT_W-1:0] shamt_q, shamt_d;

    // Whole shift resolves in the single CALC cycle.
    assign shift_value_c = (op_q == ALU_SRL) ? (b_q >> shamt_q) : (b_q << shamt_q);
    assign calc_last_c   = 1'b1;

    always_comb begin
        shamt_d = shamt_q;
        if ((state_q == IDLE) && start) begin
            shamt_d = shamt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shamt_q <= '0;
        end else begin
            shamt_q <= shamt_d;
        end
    end
`else
    logic shift_load_c;
    logic shift_en_c;
    logic shift_last_c;

    // Shifter is loaded on the accepting edge so CALC lasts exactly shamt+1 cycles.
    assign shift_load_c = (state_q == IDLE) && start && alu_is_shift(alu_ctrl_t'(ALU_control));
    assign shift_en_c   = (state_q == CALC) && alu_is_shift(op_q);
    assign calc_last_c  = !alu_is_shift(op_q) || shift_last_c;

    alu_shift_serial #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (shift_load_c),
        .shift_en  (shift_en_c),
        .dir_right (op_q == ALU_SRL),
        .din       (B),
        .amt       (shamt),
        .dout      (shift_value_c),
        .last_c    (shift_last_c)
    );
`endif

    // Result and flags of the latched operation.
    always_comb begin
        sum_c         = a_q + b_q;
        diff_c        = a_q - b_q;
        calc_result_c = '0;
        calc_flags_c  = '0;
        case (op_q)
            ALU_ADD: begin
                calc_result_c         = sum_c;
                calc_flags_c.overflow = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                        (sum_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_SUB: begin
                calc_result_c         = diff_c;
                calc_flags_c.overflow = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                        (diff_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_AND: calc_result_c = a_q & b_q;
            ALU_OR:  calc_result_c = a_q | b_q;
            ALU_SLL,
            ALU_SRL: calc_result_c = shift_value_c;
            default: calc_flags_c.illegal = 1'b1;
        endcase
        calc_flags_c.zero = (calc_result_c == '0);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = alu_ctrl_t'(ALU_control);
                    a_d     = A;
                    b_d     = B;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (calc_last_c) begin
                    result_d = calc_result_c;
                    flags_d  = calc_flags_c;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d  = (state_d == DONE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= ALU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = flags_q.zero;
    assign overflow = flags_q.overflow;
    assign illegal  = flags_q.illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: behavioural model compared every cycle,
// directed literal cases and randomized operations.
module tb_alu_exec_unit;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  ALU_control;
    logic [31:0] A, B;
    logic [4:0]  shamt;
    logic        ready, done, zero, overflow, illegal;
    logic [31:0] result;

    alu_exec_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ALU_control (ALU_control),
        .A           (A),
        .B           (B),
        .shamt       (shamt),
        .ready       (ready),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    bit          busy;
    int          edge_cnt = 0;
    int          fin_edge;
    logic [31:0] exp_res, p_res;
    bit          exp_z, exp_ov, exp_il, exp_ready, exp_done;
    bit          p_ov, p_il;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] op, input logic [4:0] sh);
        if (!FAST && (op == 3'd4 || op == 3'd5)) return int'(sh) + 2;
        return 2;
    endfunction

    function automatic void model_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] sh, output logic [31:0] r,
                                       output bit ov, output bit il);
        longint s;
        r  = '0;
        ov = 1'b0;
        il = 1'b0;
        case (op)
            3'd0: begin
                s  = longint'($signed(a)) + longint'($signed(b));
                r  = 32'(s);
                ov = (s > SMAX) || (s < SMIN);
            end
            3'd1: begin
                s  = longint'($signed(a)) - longint'($signed(b));
                r  = 32'(s);
                ov = (s > SMAX) || (s < SMIN);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = b << sh;
            3'd5: r = b >> sh;
            default: il = 1'b1;
        endcase
    endfunction

    // Advances the model by one rising edge using the inputs present at that edge.
    task automatic model_update();
        if (reset) begin
            busy      = 1'b0;
            exp_ready = 1'b1;
            exp_done  = 1'b0;
            exp_res   = '0;
            exp_z     = 1'b0;
            exp_ov    = 1'b0;
            exp_il    = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (busy) begin
                if (edge_cnt == fin_edge) begin
                    exp_res  = p_res;
                    exp_z    = (p_res == 0);
                    exp_ov   = p_ov;
                    exp_il   = p_il;
                    exp_done = 1'b1;
                end else if (edge_cnt == fin_edge + 1) begin
                    busy      = 1'b0;
                    exp_ready = 1'b1;
                end
            end else if (start) begin
                model_exec(ALU_control, A, B, shamt, p_res, p_ov, p_il);
                fin_edge  = edge_cnt + exp_lat(ALU_control, shamt) - 1;
                busy      = 1'b1;
                exp_ready = 1'b0;
            end
        end
        edge_cnt++;
    endtask

    task automatic compare_all();
        check("ready",    32'(ready),    32'(exp_ready));
        check("done",     32'(done),     32'(exp_done));
        check("result",   result,        exp_res);
        check("zero",     32'(zero),     32'(exp_z));
        check("overflow", 32'(overflow), 32'(exp_ov));
        check("illegal",  32'(illegal),  32'(exp_il));
    endtask

    // One clock: model steps on the rising edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (ready !== 1'b1) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input bit hold, output int lat);
        wait_ready();
        ALU_control = op;
        A           = a;
        B           = b;
        shamt       = sh;
        start       = 1'b1;
        tick();
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            start = hold ? 1'b1 : 1'($urandom_range(0, 1));
            A     = $urandom;
            B     = $urandom;
            shamt = 5'($urandom);
            if (!hold) ALU_control = 3'($urandom);
            tick();
            lat++;
        end
        if (!hold) start = 1'b0;
        if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int lat;
        int dones;
        reset       = 1'b1;
        start       = 1'b0;
        ALU_control = '0;
        A           = '0;
        B           = '0;
        shamt       = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_ready",  32'(ready), 32'd1);
        check("rst_done",   32'(done),  32'd0);
        check("rst_result", result,     32'd0);

        run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0, lat);
        check("add_res", result, 32'h8000_0000);
        check("add_ov",  32'(overflow), 32'd1);
        check("add_z",   32'(zero), 32'd0);
        check("add_lat", 32'(lat), 32'd2);
        tick();
        check("add_ready_c3", 32'(ready), 32'd1);

        run_op(3'd1, 32'd5, 32'd5, 5'd0, 1'b0, lat);
        check("sub_res", result, 32'd0);
        check("sub_z",   32'(zero), 32'd1);
        check("sub_ov",  32'(overflow), 32'd0);

        run_op(3'd3, 32'hF0F0_0000, 32'h0000_F0F0, 5'd0, 1'b0, lat);
        check("or_res", result, 32'hF0F0_F0F0);
        check("or_z",   32'(zero), 32'd0);

        run_op(3'd4, 32'hDEAD_BEEF, 32'h0000_0001, 5'd31, 1'b0, lat);
        check("sll31_res", result, 32'h8000_0000);
        check("sll31_lat", 32'(lat), FAST ? 32'd2 : 32'd33);

        run_op(3'd5, 32'h0, 32'h8000_0000, 5'd4, 1'b0, lat);
        check("srl4_res", result, 32'h0800_0000);
        check("srl4_lat", 32'(lat), FAST ? 32'd2 : 32'd6);

        run_op(3'd4, 32'h0, 32'h0000_1234, 5'd0, 1'b0, lat);
        check("sh0_res", result, 32'h0000_1234);
        check("sh0_lat", 32'(lat), 32'd2);

        // start held and operands toggled during a 10-bit shift
        run_op(3'd4, 32'h0, 32'h0000_0003, 5'd10, 1'b1, lat);
        check("hold_res", result, 32'h0000_0C00);
        check("hold_lat", 32'(lat), FAST ? 32'd2 : 32'd12);
        ALU_control = 3'd0;
        A           = 32'd3;
        B           = 32'd4;
        shamt       = 5'd0;
        tick();
        check("hold_done_once", 32'(done), 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 5'd0, 1'b0, lat);
        check("hold_next_res", result, 32'd7);

        // reset in the third CALC cycle of a shift
        wait_ready();
        ALU_control = 3'd4;
        B           = 32'h0000_0001;
        shamt       = 5'd10;
        start       = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        tick();
        if (done === 1'b1) dones++;
        tick();
        if (done === 1'b1) dones++;
        reset = 1'b1;
        tick();
        check("rstmid_result", result, 32'd0);
        check("rstmid_done",   32'(done), 32'd0);
        reset = 1'b0;
        tick();
        check("rstmid_ready", 32'(ready), 32'd1);
        repeat (12) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check("rstmid_no_done", 32'(dones), 32'd0);

        run_op(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 1'b0, lat);
        check("ill_res", result, 32'd0);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_ov",   32'(overflow), 32'd0);
        check("ill_lat",  32'(lat), 32'd2);
        run_op(3'd0, 32'd1, 32'd1, 5'd0, 1'b0, lat);
        check("ill_clear", 32'(illegal), 32'd0);
        check("ill_next_res", result, 32'd2);

        // randomized operations; every cycle is checked against the model
        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            repeat ($urandom_range(0, 2)) tick();
            run_op(3'($urandom), ra, rb, 5'($urandom), 1'b0, lat);
        end
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
